write_back: RTL and testbench

Final pipeline stage of the IITB-RISC core: consumes 41-bit instruction bundles from the memory-access→write-back pipeline register and commits results into `reg_file` via its write port (`wr_en`/`wr_addr`/`wr_data`) and PC-write port (`pc_wr`/`pc_next`). On a control-flow redirect (taken branch or write to R7/PC), it squashes the wrong-path bundles that follow for a fixed window. It also exposes a one-cycle forwarding tap and retire/squash counters.

---
 rtl/iitb_pkg.sv | 36 +++
 rtl/write_back.sv | 165 ++++++++++++++++
 tb/tb_write_back.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/iitb_pkg.sv
// ============================================================================
// iitb_pkg : shared bundle layout and write-back FSM encoding for IITB-RISC.
// Rev 1.0
// ============================================================================
`default_nettype none

package iitb_pkg;

  localparam int BUNDLE_W     = 41;
  localparam int RESULT_LSB   = 0;
  localparam int RESULT_MSB   = 15;
  localparam int RD_LSB       = 16;
  localparam int RD_MSB       = 18;
  localparam int REG_WE_BIT   = 19;
  localparam int SPARE_BIT    = 20;
  localparam int BR_TAKEN_BIT = 21;
  localparam int OPCODE_LSB   = 22;
  localparam int OPCODE_MSB   = 25;
  localparam int TARGET_LSB   = 26;
  localparam int TARGET_MSB   = 40;

  localparam logic [2:0] PC_REG = 3'd7;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } wb_state_e;

  // Branch targets are 15 bits wide; the PC is zero-extended to 16.
  function automatic logic [15:0] branch_pc(input logic [BUNDLE_W-1:0] b);
    return {1'b0, b[TARGET_MSB:TARGET_LSB]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/write_back.sv
// ============================================================================
// write_back : final IITB-RISC stage; commits results, redirects the PC and
//              squashes a fixed window of wrong-path bundles after a redirect.
// Rev 1.0
// ============================================================================
`default_nettype none

module write_back
  import iitb_pkg::*;
#(
  parameter int FLUSH_CYC = 3,
  parameter int CNT_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BUNDLE_W-1:0] instr_in,
  input  logic                freeze,
  output logic                wr_en,
  output logic [2:0]          wr_addr,
  output logic [15:0]         wr_data,
  output logic                pc_wr,
  output logic [15:0]         pc_next,
  output logic                flush,
  output logic                fwd_valid,
  output logic [2:0]          fwd_addr,
  output logic [15:0]         fwd_data,
  output logic [CNT_W-1:0]    retired_count,
  output logic [CNT_W-1:0]    squashed_count
);

  localparam int              SQ_W    = $clog2(FLUSH_CYC + 1);
  localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(FLUSH_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  wb_state_e         state_q, state_d;
  logic [SQ_W-1:0]   sq_cnt_q, sq_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [2:0]        wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              pc_wr_q, pc_wr_d;
  logic [15:0]       pc_next_q, pc_next_d;
  logic              flush_q, flush_d;
  logic [CNT_W-1:0]  retired_count_q, retired_count_d;
  logic [CNT_W-1:0]  squashed_count_q, squashed_count_d;

  logic              accept;
  logic              redirect;
  logic [2:0]        rd;
  logic              reg_we;
  logic              br_taken;
  logic [15:0]       result;
  logic              unused_bundle_bits;

  assign in_ready = ~freeze & ~rst;
  assign accept   = in_valid & in_ready;
  assign rd       = instr_in[RD_MSB:RD_LSB];
  assign reg_we   = instr_in[REG_WE_BIT];
  assign br_taken = instr_in[BR_TAKEN_BIT];
  assign result   = instr_in[RESULT_MSB:RESULT_LSB];
  assign unused_bundle_bits = ^{instr_in[SPARE_BIT], instr_in[OPCODE_MSB:OPCODE_LSB]};

  always_comb begin
    state_d          = state_q;
    sq_cnt_d         = sq_cnt_q;
    wr_en_d          = 1'b0;
    wr_addr_d        = '0;
    wr_data_d        = '0;
    pc_wr_d          = 1'b0;
    pc_next_d        = '0;
    redirect         = 1'b0;
    retired_count_d  = retired_count_q;
    squashed_count_d = squashed_count_q;

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (retired_count_q != CNT_MAX) begin
            retired_count_d = retired_count_q + CNT_W'(1);
          end
          // A write to R7 is itself the redirect and overrides branch_taken.
          if (reg_we && rd == PC_REG) begin
            pc_wr_d   = 1'b1;
            pc_next_d = result;
            redirect  = 1'b1;
          end else begin
            if (reg_we) begin
              wr_en_d   = 1'b1;
              wr_addr_d = rd;
              wr_data_d = result;
            end
            if (br_taken) begin
              pc_wr_d   = 1'b1;
              pc_next_d = branch_pc(instr_in);
              redirect  = 1'b1;
            end
          end
          if (redirect) begin
            state_d  = ST_SQUASH;
            sq_cnt_d = SQ_LOAD;
          end
        end
      end
      ST_SQUASH: begin
        // The window only advances on accepted bundles, so freeze stalls it.
        if (accept) begin
          if (squashed_count_q != CNT_MAX) begin
            squashed_count_d = squashed_count_q + CNT_W'(1);
          end
          sq_cnt_d = sq_cnt_q - SQ_W'(1);
          if (sq_cnt_q == SQ_W'(1)) begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    flush_d = (state_d == ST_SQUASH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_RUN;
      sq_cnt_q         <= '0;
      wr_en_q          <= 1'b0;
      wr_addr_q        <= '0;
      wr_data_q        <= '0;
      pc_wr_q          <= 1'b0;
      pc_next_q        <= '0;
      flush_q          <= 1'b0;
      retired_count_q  <= '0;
      squashed_count_q <= '0;
    end else begin
      state_q          <= state_d;
      sq_cnt_q         <= sq_cnt_d;
      wr_en_q          <= wr_en_d;
      wr_addr_q        <= wr_addr_d;
      wr_data_q        <= wr_data_d;
      pc_wr_q          <= pc_wr_d;
      pc_next_q        <= pc_next_d;
      flush_q          <= flush_d;
      retired_count_q  <= retired_count_d;
      squashed_count_q <= squashed_count_d;
    end
  end

  assign wr_en          = wr_en_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign pc_wr          = pc_wr_q;
  assign pc_next        = pc_next_q;
  assign flush          = flush_q;
  assign fwd_valid      = wr_en_q;
  assign fwd_addr       = wr_addr_q;
  assign fwd_data       = wr_data_q;
  assign retired_count  = retired_count_q;
  assign squashed_count = squashed_count_q;

endmodule

`default_nettype wire

// File: tb/tb_write_back.sv
// ============================================================================
// tb_write_back : scoreboard bench for write_back.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_write_back;

  localparam int FLUSH = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [40:0] instr_in;
  logic        freeze;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        pc_wr;
  logic [15:0] pc_next;
  logic        flush;
  logic        fwd_valid;
  logic [2:0]  fwd_addr;
  logic [15:0] fwd_data;
  logic [31:0] retired_count;
  logic [31:0] squashed_count;

  write_back #(.FLUSH_CYC(FLUSH), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .freeze(freeze),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pc_wr(pc_wr), .pc_next(pc_next), .flush(flush),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .retired_count(retired_count), .squashed_count(squashed_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        pc_wr;
    logic [15:0] pc_next;
    logic        flush;
    logic [31:0] ret;
    logic [31:0] sqd;
    int          cnt;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          m_sq;
  int          m_cnt;
  logic [31:0] m_ret;
  logic [31:0] m_sqd;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [40:0] mk(input logic [15:0] res, input logic [2:0] rd,
                                     input logic we, input logic br, input logic [14:0] tgt);
    logic [40:0] b;
    b = '0;
    b[15:0]  = res;
    b[18:16] = rd;
    b[19]    = we;
    b[21]    = br;
    b[25:22] = 4'ha;
    b[40:26] = tgt;
    return b;
  endfunction

  // Drive one cycle, predict its effect, then compare the registered results.
  task automatic step(input logic r, input logic v, input logic [40:0] ins, input logic frz);
    exp_t e;
    bit   acc;
    logic [2:0]  rd;
    logic        we, br;
    rst = r; in_valid = v; instr_in = ins; freeze = frz;
    #1;
    check_eq("in_ready", {63'd0, in_ready}, {63'd0, !frz && !r});
    acc = v && !frz && !r;
    rd  = ins[18:16];
    we  = ins[19];
    br  = ins[21];
    e.wr_en = 0; e.wr_addr = 0; e.wr_data = 0; e.pc_wr = 0; e.pc_next = 0;
    if (r) begin
      m_sq = 0; m_cnt = 0; m_ret = 0; m_sqd = 0;
    end else if (acc) begin
      if (!m_sq) begin
        if (m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 1;
        if (we && rd == 3'd7) begin
          e.pc_wr = 1; e.pc_next = ins[15:0];
          m_sq = 1; m_cnt = FLUSH;
        end else begin
          if (we) begin
            e.wr_en = 1; e.wr_addr = rd; e.wr_data = ins[15:0];
          end
          if (br) begin
            e.pc_wr = 1; e.pc_next = {1'b0, ins[40:26]};
            m_sq = 1; m_cnt = FLUSH;
          end
        end
      end else begin
        if (m_sqd != 32'hFFFF_FFFF) m_sqd = m_sqd + 1;
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_sq = 0;
      end
    end
    e.flush = m_sq;
    e.ret   = m_ret;
    e.sqd   = m_sqd;
    e.cnt   = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("wr_en",     {63'd0, wr_en},     {63'd0, e.wr_en});
    check_eq("wr_addr",   {61'd0, wr_addr},   {61'd0, e.wr_addr});
    check_eq("wr_data",   {48'd0, wr_data},   {48'd0, e.wr_data});
    check_eq("fwd_valid", {63'd0, fwd_valid}, {63'd0, e.wr_en});
    check_eq("fwd_addr",  {61'd0, fwd_addr},  {61'd0, e.wr_addr});
    check_eq("fwd_data",  {48'd0, fwd_data},  {48'd0, e.wr_data});
    check_eq("pc_wr",     {63'd0, pc_wr},     {63'd0, e.pc_wr});
    check_eq("pc_next",   {48'd0, pc_next},   {48'd0, e.pc_next});
    check_eq("flush",     {63'd0, flush},     {63'd0, e.flush});
    check_eq("retired",   {32'd0, retired_count},  {32'd0, e.ret});
    check_eq("squashed",  {32'd0, squashed_count}, {32'd0, e.sqd});
    check_eq("sq_cnt",    64'(dut.sq_cnt_q),       64'(e.cnt));
  endtask

  task automatic go(input logic [40:0] ins);
    step(1'b0, 1'b1, ins, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, mk(16'hdead, 3'd5, 1'b1, 1'b0, 15'h0), 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr_in = '0; freeze = 1'b0;
    m_sq = 0; m_cnt = 0; m_ret = 0; m_sqd = 0;
    @(posedge clk);
    #1;

    // reset (valid held high to see in_ready low under reset)
    step(1'b1, 1'b1, mk(16'h5555, 3'd1, 1'b1, 1'b0, 15'h0), 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);

    // plain register commit, then bubble
    go(mk(16'h1234, 3'd3, 1'b1, 1'b0, 15'h0));
    idle();

    // write to R7 redirects; next three are squashed, the fifth commits
    go(mk(16'h0040, 3'd7, 1'b1, 1'b1, 15'h0222));
    go(mk(16'h1111, 3'd1, 1'b1, 1'b0, 15'h0));
    go(mk(16'h2222, 3'd2, 1'b1, 1'b0, 15'h0));
    go(mk(16'h3333, 3'd3, 1'b1, 1'b0, 15'h0));
    go(mk(16'h4444, 3'd4, 1'b1, 1'b0, 15'h0));

    // taken branch with link write in the same cycle
    go(mk(16'h0011, 3'd2, 1'b1, 1'b1, 15'h0100));

    // freeze inside the window, then exactly FLUSH squashed bundles
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, mk(16'h0bad, 3'd6, 1'b1, 1'b0, 15'h0), 1'b1);
    go(mk(16'h0a01, 3'd1, 1'b1, 1'b1, 15'h0010));
    go(mk(16'h0a02, 3'd2, 1'b1, 1'b0, 15'h0));
    go(mk(16'h0a03, 3'd3, 1'b1, 1'b0, 15'h0));
    go(mk(16'h0a04, 3'd4, 1'b1, 1'b0, 15'h0));
    go(mk(16'h0000, 3'd0, 1'b0, 1'b0, 15'h0));

    // reset in the middle of a window
    go(mk(16'h0000, 3'd0, 1'b0, 1'b1, 15'h7fff));
    go(mk(16'h0b01, 3'd1, 1'b1, 1'b0, 15'h0));
    step(1'b1, 1'b1, mk(16'h0b02, 3'd2, 1'b1, 1'b0, 15'h0), 1'b0);
    go(mk(16'h0c05, 3'd5, 1'b1, 1'b0, 15'h0));

    // saturation of the retire counter
    force dut.retired_count_q = 32'hFFFF_FFFE;
    #2;
    release dut.retired_count_q;
    m_ret = 32'hFFFF_FFFE;
    #2;
    step(1'b0, 1'b1, mk(16'h0001, 3'd1, 1'b1, 1'b0, 15'h0), 1'b0);
    go(mk(16'h0002, 3'd2, 1'b1, 1'b0, 15'h0));
    go(mk(16'h0003, 3'd3, 1'b0, 1'b0, 15'h0));

    // random mix of bundles, bubbles and freezes
    for (int i = 0; i < 60; i++) begin
      logic [40:0] b;
      b = mk(16'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom_range(0, 3) == 0),
             15'($urandom));
      step(1'b0, 1'($urandom_range(0, 3) != 0), b, 1'($urandom_range(0, 5) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
